// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM command-port arbiter: FSM encoding,
// timeout fill value and the index-width helper.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_WR_REQ  = 2'd1,
        ARB_RD_REQ  = 2'd2,
        ARB_RD_WAIT = 2'd3
    } arb_state_t;

    // Wide enough for any data bus in use; users keep the low DATA_W bits.
    localparam logic [63:0] RD_TIMEOUT_DATA = '1;

    // Bits needed to index n items, never less than one.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first requester after `last`, in
// circular order. Shared with future DMA arbitration.
module rr_pick
    import sdram_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] cand;

    // NOTE: every variable driven here gets a value before any branch, so no latch is inferred.
    always_comb begin
        idx  = last;
        any  = 1'b0;
        cand = last;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(last) + k) % N);
            if (!any && req[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares the single read/write command port of my_sdram_ctrl between
// NUM_CLIENTS requesters, one outstanding transaction at a time.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_CLIENTS = 2,
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 16,
    parameter int RD_TIMEOUT  = 1024
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_CLIENTS-1:0]        c_req,
    input  logic [NUM_CLIENTS-1:0]        c_we,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] c_addr,
    input  logic [NUM_CLIENTS*DATA_W-1:0] c_wdata,
    output logic [NUM_CLIENTS-1:0]        c_ack,
    output logic [NUM_CLIENTS-1:0]        c_rvalid,
    output logic [DATA_W-1:0]             rdata,
    output logic                          rd_timeout,
    output logic [ADDR_W-1:0]             ctrl_w_addr,
    output logic [ADDR_W-1:0]             ctrl_r_addr,
    output logic [DATA_W-1:0]             ctrl_din,
    output logic                          ctrl_write_req,
    output logic                          ctrl_read_req,
    input  logic                          ctrl_write_gnt,
    input  logic                          ctrl_read_gnt,
    input  logic [DATA_W-1:0]             ctrl_dout,
    input  logic                          ctrl_read_valid,
    input  logic                          ctrl_busy
);

    localparam int IDX_W = clog2(NUM_CLIENTS);
    localparam int CNT_W = clog2(RD_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

    arb_state_t state, state_n;

    logic [IDX_W-1:0]       last_grant, lat_idx, pick_idx;
    logic                   pick_any, take;
    logic [ADDR_W-1:0]      lat_addr;
    logic [DATA_W-1:0]      lat_wdata;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic                   wgnt_q, rgnt_q, rvalid_q;
    logic                   wgnt_rise, rgnt_rise, rvalid_rise;
    logic [NUM_CLIENTS-1:0] ack_n, rvalid_n;
    logic [DATA_W-1:0]      rdata_n;
    logic                   timeout_n;

    logic [ADDR_W-1:0] addr_arr  [NUM_CLIENTS];
    logic [DATA_W-1:0] wdata_arr [NUM_CLIENTS];

    for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_unpack
        assign addr_arr[g]  = c_addr[g*ADDR_W +: ADDR_W];
        assign wdata_arr[g] = c_wdata[g*DATA_W +: DATA_W];
    end

    rr_pick #(
        .N  (NUM_CLIENTS),
        .IW (IDX_W)
    ) u_pick (
        .req  (c_req),
        .last (last_grant),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // Controller handshakes may be levels or pulses; only the rising edge is an event.
    assign wgnt_rise   = ctrl_write_gnt  & ~wgnt_q;
    assign rgnt_rise   = ctrl_read_gnt   & ~rgnt_q;
    assign rvalid_rise = ctrl_read_valid & ~rvalid_q;

    assign ctrl_write_req = (state == ARB_WR_REQ);
    assign ctrl_read_req  = (state == ARB_RD_REQ);
    assign ctrl_w_addr    = lat_addr;
    assign ctrl_r_addr    = lat_addr;
    assign ctrl_din       = lat_wdata;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        take      = 1'b0;
        ack_n     = '0;
        rvalid_n  = '0;
        rdata_n   = rdata;
        timeout_n = rd_timeout;
        cnt_n     = cnt;
        case (state)
            ARB_IDLE: begin
                if (!ctrl_busy && pick_any) begin
                    take    = 1'b1;
                    state_n = c_we[pick_idx] ? ARB_WR_REQ : ARB_RD_REQ;
                end
            end
            ARB_WR_REQ: begin
                if (wgnt_rise) begin
                    ack_n[lat_idx] = 1'b1;
                    state_n        = ARB_IDLE;
                end
            end
            ARB_RD_REQ: begin
                if (rgnt_rise) begin
                    ack_n[lat_idx] = 1'b1;
                    cnt_n          = '0;
                    state_n        = ARB_RD_WAIT;
                end
            end
            ARB_RD_WAIT: begin
                // Real data beats the watchdog when both land on the same edge.
                if (rvalid_rise) begin
                    rdata_n           = ctrl_dout;
                    rvalid_n[lat_idx] = 1'b1;
                    state_n           = ARB_IDLE;
                end else if (cnt == CNT_LAST) begin
                    rdata_n           = RD_TIMEOUT_DATA[DATA_W-1:0];
                    rvalid_n[lat_idx] = 1'b1;
                    timeout_n         = 1'b1;
                    state_n           = ARB_IDLE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: state_n = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_grant <= IDX_W'(NUM_CLIENTS - 1);
            lat_idx    <= '0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            cnt        <= '0;
            wgnt_q     <= 1'b0;
            rgnt_q     <= 1'b0;
            rvalid_q   <= 1'b0;
            c_ack      <= '0;
            c_rvalid   <= '0;
            rdata      <= '0;
            rd_timeout <= 1'b0;
        end else begin
            wgnt_q     <= ctrl_write_gnt;
            rgnt_q     <= ctrl_read_gnt;
            rvalid_q   <= ctrl_read_valid;
            cnt        <= cnt_n;
            c_ack      <= ack_n;
            c_rvalid   <= rvalid_n;
            rdata      <= rdata_n;
            rd_timeout <= timeout_n;
            if (take) begin
                lat_idx    <= pick_idx;
                lat_addr   <= addr_arr[pick_idx];
                lat_wdata  <= wdata_arr[pick_idx];
                last_grant <= pick_idx;
            end
        end
    end

endmodule
